// File: rtl/accumulator_bus_responder.sv
// Memory-side responder for the shared accumulator bus: a LIFO of operands served
// through a four-phase op/signal handshake, reporting DONE once a single value remains.
module accumulator_bus_responder #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int NPROC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    op,
    output logic          signal,
    output logic [DW-1:0] read,
    input  logic [DW-1:0] write,
    input  logic [DW-1:0] load,
    input  logic          load_en,
    output logic          full,
    output logic [AW-1:0] index,
    output logic [DW-1:0] preview,
    output logic [4:0]    state
);

    // Handshake: op is held by the processor until signal rises; signal then stays
    // high (with read stable) until op returns to IDLE, and drops the next clock.

    // Pending-pop counter must at least cover the stack depth and the processor count.
    localparam int PW = ($clog2(NPROC) > AW) ? $clog2(NPROC) + 1 : AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_READ  = 5'b00010,
        S_WRITE = 5'b00100,
        S_ACK   = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          loaded_q, loaded_d;
    logic          signal_q, signal_d;
    logic [DW-1:0] read_q, read_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic          push_en;
    logic [DW-1:0] push_data;
    logic [AW-1:0] top_idx;
    logic          empty;
    logic          done_cond;

    // Low count bits wrap to DEPTH-1 when full, which is exactly the top slot.
    assign top_idx = count_q[AW-1:0] - AW'(1);
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign index   = full ? {AW{1'b1}} : count_q[AW-1:0];
    assign preview = empty ? '0 : mem_q[top_idx];

    assign done_cond = loaded_q && (count_q == (AW+1)'(1)) && (pend_q == '0)
                       && !load_en && (op == OP_IDLE);

    assign signal = signal_q;
    assign read   = (state_q == S_DONE) ? preview : read_q;
    assign state  = state_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_d    = pend_q;
        loaded_d  = loaded_q;
        signal_d  = signal_q;
        read_d    = read_q;
        push_en   = 1'b0;
        push_data = '0;

        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    loaded_d = 1'b1;
                    if (!full) begin
                        push_en   = 1'b1;
                        push_data = load;
                        count_d   = count_q + (AW+1)'(1);
                    end
                end else if (done_cond) begin
                    state_d = S_DONE;
                end else if (op == OP_READ) begin
                    state_d = S_READ;
                end else if (op == OP_WRITE) begin
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                if (!empty) begin
                    read_d   = preview;
                    signal_d = 1'b1;
                    count_d  = count_q - (AW+1)'(1);
                    pend_d   = pend_q + PW'(1);
                    state_d  = S_ACK;
                end else begin
                    signal_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (!full) begin
                    push_en   = 1'b1;
                    push_data = write;
                    count_d   = count_q + (AW+1)'(1);
                    signal_d  = 1'b1;
                    // A sum may arrive without two matching pops; clamp at zero.
                    pend_d    = (pend_q >= PW'(2)) ? pend_q - PW'(2) : '0;
                    state_d   = S_ACK;
                end else begin
                    signal_d = 1'b0;
                end
            end
            S_ACK: begin
                if (op == OP_IDLE) begin
                    signal_d = 1'b0;
                    read_d   = '0;
                    state_d  = S_IDLE;
                end
            end
            S_DONE: begin
                signal_d = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                signal_d = 1'b0;
                read_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            pend_q   <= '0;
            loaded_q <= 1'b0;
            signal_q <= 1'b0;
            read_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            loaded_q <= loaded_d;
            signal_q <= signal_d;
            read_q   <= read_d;
        end
    end

    // Storage has no reset; an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[count_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_accumulator_bus_responder.sv
// Directed bench for accumulator_bus_responder: reset, preload, pop, full reduction
// to DONE, and full/priority boundaries.
module tb_accumulator_bus_responder;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic [1:0]    op;
    logic          signal;
    logic [DW-1:0] read;
    logic [DW-1:0] write;
    logic [DW-1:0] load;
    logic          load_en;
    logic          full;
    logic [AW-1:0] index;
    logic [DW-1:0] preview;
    logic [4:0]    state;

    int checks;
    int failures;

    accumulator_bus_responder #(.DW(DW), .AW(AW), .NPROC(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .signal  (signal),
        .read    (read),
        .write   (write),
        .load    (load),
        .load_en (load_en),
        .full    (full),
        .index   (index),
        .preview (preview),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        op      = 2'b00;
        load_en = 1'b0;
        load    = '0;
        write   = '0;
        reset   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Back-to-back preload of base, base+step, ... (n values); load_en stays high throughout.
    task automatic preload(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            load_en = 1'b1;
            load    = DW'(base + i * step);
            tick();
        end
        load_en = 1'b0;
        load    = '0;
    endtask

    // Drive one bus op, wait (bounded) for signal, capture read, then release op.
    task automatic bus_op(input logic [1:0] o, input logic [DW-1:0] wd,
                          output int lat, output logic [DW-1:0] rd);
        op    = o;
        write = wd;
        lat   = -1;
        rd    = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (signal === 1'b1) begin
                lat = i;
                rd  = read;
                break;
            end
        end
        op    = 2'b00;
        write = '0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== 5'b00001 || index !== '0 || preview !== '0 || signal !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: state=%b index=%0d preview=%0d signal=%b, want 00001/0/0/0",
                     state, index, preview, signal);
        end
        preload(2, 1, 1);
        op    = 2'b10;
        write = 32'd9;
        for (int i = 0; i < 8 && signal !== 1'b1; i++) tick();
        checks++;
        if (signal !== 1'b1) begin
            failures++;
            $display("FAIL reset_write_ack: signal=%b, want 1", signal);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (signal !== 1'b0 || state !== 5'b00001 || index !== '0 || preview !== '0
            || read !== '0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ack: signal=%b state=%b index=%0d preview=%0d read=%0d full=%b, want 0/00001/0/0/0/0",
                     signal, state, index, preview, read, full);
        end
        op    = 2'b00;
        write = '0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_preload();
        do_reset();
        preload(3, 3, 2);
        tick();
        tick();
        checks++;
        if (index !== 10'd3 || preview !== 32'd7) begin
            failures++;
            $display("FAIL preload: index=%0d preview=%0d, want 3/7", index, preview);
        end
        checks++;
        if (state !== 5'b00001) begin
            failures++;
            $display("FAIL preload_no_done: state=%b, want 00001", state);
        end
    endtask

    task automatic test_read();
        int lat;
        logic [DW-1:0] rd;
        bus_op(2'b01, '0, lat, rd);
        checks++;
        if (lat != 2 || rd !== 32'd7) begin
            failures++;
            $display("FAIL read_pop: latency=%0d read=%0d, want 2/7", lat, rd);
        end
        checks++;
        if (signal !== 1'b0 || read !== '0 || index !== 10'd2 || preview !== 32'd5) begin
            failures++;
            $display("FAIL read_release: signal=%b read=%0d index=%0d preview=%0d, want 0/0/2/5",
                     signal, read, index, preview);
        end
    endtask

    task automatic test_full_sum();
        logic [1:0]    s_op  [9] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        logic [DW-1:0] s_val [9] = '{32'd4, 32'd3, 32'd7, 32'd7, 32'd2, 32'd9, 32'd9, 32'd1, 32'd10};
        int lat;
        logic [DW-1:0] rd;
        do_reset();
        preload(4, 1, 1);
        for (int k = 0; k < 9; k++) begin
            bus_op(s_op[k], (s_op[k] == 2'b10) ? s_val[k] : '0, lat, rd);
            checks++;
            if (lat != 2 || (s_op[k] == 2'b01 && rd !== s_val[k])) begin
                failures++;
                $display("FAIL sum_step%0d: latency=%0d read=%0d, want 2/%0d",
                         k, lat, rd, s_val[k]);
            end
        end
        tick();
        checks++;
        if (state !== 5'b10000 || read !== 32'd10 || index !== 10'd1 || preview !== 32'd10) begin
            failures++;
            $display("FAIL sum_done: state=%b read=%0d index=%0d preview=%0d, want 10000/10/1/10",
                     state, read, index, preview);
        end
        op = 2'b01;
        repeat (4) tick();
        checks++;
        if (signal !== 1'b0 || state !== 5'b10000 || read !== 32'd10) begin
            failures++;
            $display("FAIL done_ignores_op: signal=%b state=%b read=%0d, want 0/10000/10",
                     signal, state, read);
        end
        op = 2'b00;
    endtask

    task automatic test_full_stall();
        do_reset();
        preload(1023, 0, 1);
        load_en = 1'b1;
        checks++;
        if (full !== 1'b0 || index !== 10'd1023) begin
            failures++;
            $display("FAIL almost_full: full=%b index=%0d, want 0/1023", full, index);
        end
        load = 32'd1023;
        tick();
        load_en = 1'b0;
        checks++;
        if (full !== 1'b1 || index !== 10'd1023 || preview !== 32'd1023) begin
            failures++;
            $display("FAIL full: full=%b index=%0d preview=%0d, want 1/1023/1023",
                     full, index, preview);
        end
        op    = 2'b10;
        write = 32'd55;
        repeat (5) tick();
        checks++;
        if (signal !== 1'b0 || state !== 5'b00100 || preview !== 32'd1023) begin
            failures++;
            $display("FAIL write_stall_full: signal=%b state=%b preview=%0d, want 0/00100/1023",
                     signal, state, preview);
        end
        op    = 2'b00;
        write = '0;
    endtask

    task automatic test_load_priority();
        int lat;
        do_reset();
        load_en = 1'b1;
        load    = 32'd11;
        tick();
        load = 32'd22;
        op   = 2'b01;
        tick();
        load_en = 1'b0;
        load    = '0;
        checks++;
        if (state !== 5'b00001 || index !== 10'd2 || preview !== 32'd22) begin
            failures++;
            $display("FAIL load_priority: state=%b index=%0d preview=%0d, want 00001/2/22",
                     state, index, preview);
        end
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (signal === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 2 || read !== 32'd22 || index !== 10'd1) begin
            failures++;
            $display("FAIL op_after_load: latency=%0d read=%0d index=%0d, want 2/22/1",
                     lat, read, index);
        end
        op = 2'b11;
        tick();
        tick();
        checks++;
        if (signal !== 1'b1 || state !== 5'b01000) begin
            failures++;
            $display("FAIL ack_hold_nonzero_op: signal=%b state=%b, want 1/01000", signal, state);
        end
        op = 2'b00;
        tick();
        checks++;
        if (signal !== 1'b0 || read !== '0 || state !== 5'b00001) begin
            failures++;
            $display("FAIL ack_release: signal=%b read=%0d state=%b, want 0/0/00001",
                     signal, read, state);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        op       = 2'b00;
        load_en  = 1'b0;
        load     = '0;
        write    = '0;
        test_reset();
        test_preload();
        test_read();
        test_full_sum();
        test_full_stall();
        test_load_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
